mmio_gpio_bank: RTL and testbench

Parametrised memory-mapped GPIO register bank sitting on the CPU data bus (dmem_*) beside the mcu, replacing the fixed LED/LCD/GPIO byte registers of the board top with NUM_PORTS identical 8-bit ports. Each port has output, direction, synchronised input, per-bit edge select, sticky edge flags with write-1-to-clear, and interrupt enable. The bank reads back through a registered address so its rdata can be OR-merged with other dmem_rdata_io sources. A single level irq output summarises all enabled flags.

---
 rtl/mmio_gpio_pkg.sv | 34 +++
 rtl/mmio_gpio_bank_if.sv | 13 +
 rtl/mmio_gpio_port.sv | 69 ++++++
 rtl/mmio_gpio_bank.sv | 97 +++++++++
 tb/tb_mmio_gpio_bank.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_gpio_pkg.sv
// Shared constants, register layout and address-decode helpers for the GPIO bank.
package mmio_gpio_pkg;

    localparam int PORT_STRIDE = 8;

    localparam logic [2:0] OFS_OUT  = 3'd0;
    localparam logic [2:0] OFS_DIR  = 3'd1;
    localparam logic [2:0] OFS_IN   = 3'd2;
    localparam logic [2:0] OFS_FLAG = 3'd3;
    localparam logic [2:0] OFS_IE   = 3'd4;
    localparam logic [2:0] OFS_EDGE = 3'd5;

    typedef struct packed {
        logic [7:0] edge_sel;
        logic [7:0] ie;
        logic [7:0] flag;
        logic [7:0] pin_in;
        logic [7:0] dir;
        logic [7:0] out_val;
    } port_regs_t;

    // An odd byte is written by any odd-address access or by a word access to its pair.
    function automatic logic offset_written(input logic [2:0] addr_ofs, input logic byt,
                                            input logic [2:0] ofs);
        logic same_word;
        same_word = (addr_ofs[2:1] == ofs[2:1]);
        if (ofs[0]) begin
            offset_written = same_word && (addr_ofs[0] || !byt);
        end else begin
            offset_written = same_word && !addr_ofs[0];
        end
    endfunction

endpackage

// File: rtl/mmio_gpio_bank_if.sv
// CPU data-bus slice seen by the GPIO bank.
interface mmio_gpio_bank_if #(parameter int ADDR_WIDTH = 10);

    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic                  dmem_wen;
    logic                  dmem_byt;
    logic [15:0]           dmem_wdata;
    logic [15:0]           dmem_rdata;

    modport master (output dmem_addr, dmem_wen, dmem_byt, dmem_wdata, input dmem_rdata);
    modport slave  (input dmem_addr, dmem_wen, dmem_byt, dmem_wdata, output dmem_rdata);

endinterface

// File: rtl/mmio_gpio_port.sv
// One 8-bit GPIO port: registers, input synchroniser, edge detection and sticky flags.
module mmio_gpio_port
    import mmio_gpio_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       armed,
    input  logic [7:0] pins,
    input  logic       wr_hit,
    input  logic [2:0] addr_ofs,
    input  logic       byt,
    input  logic [15:0] wdata,
    output port_regs_t regs,
    output logic       irq_term
);

    logic [7:0] s1_r, s2_r, s3_r;
    logic [7:0] out_r, dir_r, flag_r, ie_r, edge_r;
    logic [7:0] event_s, w1c_s;

    // Edge events and write-1-to-clear mask for this cycle.
    always_comb begin
        event_s = 8'h00;
        w1c_s   = 8'h00;
        if (armed) begin
            event_s = ~dir_r & ((~edge_r & s2_r & ~s3_r) | (edge_r & ~s2_r & s3_r));
        end else begin
            event_s = 8'h00;
        end
        if (wr_hit && offset_written(addr_ofs, byt, OFS_FLAG)) begin
            w1c_s = wdata[15:8];
        end else begin
            w1c_s = 8'h00;
        end
    end

    // Port registers, synchroniser chain and sticky flags.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r   <= 8'h00;
            s2_r   <= 8'h00;
            s3_r   <= 8'h00;
            out_r  <= 8'h00;
            dir_r  <= 8'h00;
            flag_r <= 8'h00;
            ie_r   <= 8'h00;
            edge_r <= 8'h00;
        end else begin
            s1_r   <= pins;
            s2_r   <= s1_r;
            s3_r   <= s2_r;
            // A new event wins over a clear landing in the same cycle.
            flag_r <= (flag_r & ~w1c_s) | event_s;
            if (wr_hit && offset_written(addr_ofs, byt, OFS_OUT))  out_r  <= wdata[7:0];
            if (wr_hit && offset_written(addr_ofs, byt, OFS_DIR))  dir_r  <= wdata[15:8];
            if (wr_hit && offset_written(addr_ofs, byt, OFS_IE))   ie_r   <= wdata[7:0];
            if (wr_hit && offset_written(addr_ofs, byt, OFS_EDGE)) edge_r <= wdata[15:8];
        end
    end

    assign regs.out_val  = out_r;
    assign regs.dir      = dir_r;
    assign regs.pin_in   = s2_r;
    assign regs.flag     = flag_r;
    assign regs.ie       = ie_r;
    assign regs.edge_sel = edge_r;
    assign irq_term      = |(flag_r & ie_r);

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped bank of NUM_PORTS GPIO ports: address decode, registered read address,
// read mux (zero outside the window so it can be OR-merged), arming counter and irq.
module mmio_gpio_bank
    import mmio_gpio_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 'h080
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    mmio_gpio_bank_if.slave        bus,
    input  logic [8*NUM_PORTS-1:0] gpio_i,
    output logic [8*NUM_PORTS-1:0] gpio_o,
    output logic [8*NUM_PORTS-1:0] gpio_oe,
    output logic                   irq
);

    localparam int PW = ADDR_WIDTH - 3;
    localparam logic [ADDR_WIDTH:0] BASE_X   = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] WIN_SIZE = (ADDR_WIDTH+1)'(PORT_STRIDE * NUM_PORTS);

    logic [ADDR_WIDTH-1:0] addr_d_r;
    logic [1:0]            arm_cnt_r;
    logic                  irq_r;
    logic                  armed_s;
    // One extra bit so an address below the base wraps to a value beyond the window.
    logic [ADDR_WIDTH:0]   rel_w_s, rel_d_s;
    logic                  win_w_s, win_d_s;
    port_regs_t            regs_s [NUM_PORTS];
    port_regs_t            sel_s;
    logic [NUM_PORTS-1:0]  irq_term_s;
    logic [15:0]           rdata_s;

    assign rel_w_s = {1'b0, bus.dmem_addr} - BASE_X;
    assign rel_d_s = {1'b0, addr_d_r} - BASE_X;
    assign win_w_s = (rel_w_s < WIN_SIZE);
    assign win_d_s = (rel_d_s < WIN_SIZE);
    assign armed_s = (arm_cnt_r == 2'd3);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic hit_s;
        assign hit_s = bus.dmem_wen && win_w_s && (rel_w_s[ADDR_WIDTH-1:3] == PW'(p));

        mmio_gpio_port u_port (
            .sys_clk  (sys_clk),
            .rst_n    (rst_n),
            .armed    (armed_s),
            .pins     (gpio_i[8*p +: 8]),
            .wr_hit   (hit_s),
            .addr_ofs (rel_w_s[2:0]),
            .byt      (bus.dmem_byt),
            .wdata    (bus.dmem_wdata),
            .regs     (regs_s[p]),
            .irq_term (irq_term_s[p])
        );

        assign gpio_o[8*p +: 8]  = regs_s[p].out_val;
        assign gpio_oe[8*p +: 8] = regs_s[p].dir;
    end

    // Read-address latch, arming counter and summary interrupt.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_d_r  <= {ADDR_WIDTH{1'b0}};
            arm_cnt_r <= 2'd0;
            irq_r     <= 1'b0;
        end else begin
            addr_d_r <= bus.dmem_addr;
            if (!armed_s) arm_cnt_r <= arm_cnt_r + 2'd1;
            irq_r <= |irq_term_s;
        end
    end

    // Read mux on the previous cycle's address.
    always_comb begin
        sel_s   = '0;
        rdata_s = 16'h0000;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_s = sel_s | ((rel_d_s[ADDR_WIDTH-1:3] == PW'(p)) ? regs_s[p] : '0);
        end
        if (win_d_s) begin
            case (rel_d_s[2:1])
                2'd0:    rdata_s = {sel_s.dir, sel_s.out_val};
                2'd1:    rdata_s = {sel_s.flag, sel_s.pin_in};
                2'd2:    rdata_s = {sel_s.edge_sel, sel_s.ie};
                default: rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = 16'h0000;
        end
    end

    assign bus.dmem_rdata = rdata_s;
    assign irq            = irq_r;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Directed bench for mmio_gpio_bank with four ports at base 'h080.
module tb_mmio_gpio_bank;

    localparam int AW = 10;
    localparam logic [AW-1:0] BASE = 10'h080;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_oe;
    logic        irq;
    int          n_tests = 0;
    int          n_fail  = 0;

    mmio_gpio_bank_if #(.ADDR_WIDTH(AW)) bus ();

    mmio_gpio_bank #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .BASE_ADDR('h080)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic bus_write(input logic [AW-1:0] a, input logic [15:0] d, input logic byt);
        @(negedge sys_clk);
        bus.dmem_addr  = a;
        bus.dmem_wen   = 1'b1;
        bus.dmem_byt   = byt;
        bus.dmem_wdata = d;
        @(negedge sys_clk);
        bus.dmem_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [15:0] d);
        @(negedge sys_clk);
        bus.dmem_addr = a;
        @(negedge sys_clk);
        d = bus.dmem_rdata;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        logic        bad;
        rst_n = 1'b0;
        gpio_i = 32'hFFFF_FFFF;
        bus.dmem_addr = BASE;
        bus.dmem_wen = 1'b0;
        bus.dmem_byt = 1'b0;
        bus.dmem_wdata = 16'h0000;
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if ({gpio_o, gpio_oe, irq, bus.dmem_rdata} !== 81'd0) begin
            n_fail++;
            $display("FAIL reset_state: o=%h oe=%h irq=%b rdata=%h required all 0", gpio_o, gpio_oe, irq, bus.dmem_rdata);
        end
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (irq !== 1'b0 || gpio_o !== 32'h0 || gpio_oe !== 32'h0) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: irq/gpio_o/gpio_oe moved after release, required 0");
        end
        for (int p = 0; p < 4; p++) begin
            bus_read(BASE + 10'(8*p + 2), rd);
            n_tests++;
            if (rd !== 16'h00FF) begin
                n_fail++;
                $display("FAIL reset_flag_in port%0d: got %h required 00ff", p, rd);
            end
        end
        gpio_i = 32'h0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_word_write();
        logic [15:0] rd;
        bus_write(BASE, 16'hA55A, 1'b0);
        n_tests++;
        if (gpio_o[7:0] !== 8'h5A || gpio_oe[7:0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL word_write: out=%h dir=%h required 5a a5", gpio_o[7:0], gpio_oe[7:0]);
        end
        bus_read(BASE, rd);
        n_tests++;
        if (rd !== 16'hA55A) begin
            n_fail++;
            $display("FAIL word_read: got %h required a55a", rd);
        end
        bus_write(BASE + 10'd1, 16'h3C00, 1'b1);
        n_tests++;
        if (gpio_o[7:0] !== 8'h5A || gpio_oe[7:0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL odd_byte_write: out=%h dir=%h required 5a 3c", gpio_o[7:0], gpio_oe[7:0]);
        end
        bus_write(BASE + 10'd4, 16'h77FF, 1'b1);
        bus_read(BASE + 10'd4, rd);
        n_tests++;
        if (rd !== 16'h00FF) begin
            n_fail++;
            $display("FAIL even_byte_write: got %h required 00ff", rd);
        end
        bus_write(BASE + 10'd4, 16'h0000, 1'b0);
    endtask

    task automatic test_rising_irq();
        bus_write(BASE + 10'd12, 16'h0001, 1'b0);
        @(negedge sys_clk);
        bus.dmem_addr = BASE + 10'd10;
        gpio_i[8] = 1'b1;
        @(negedge sys_clk);
        n_tests++;
        if (bus.dmem_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL rise_k: got %h required 0000", bus.dmem_rdata);
        end
        @(negedge sys_clk);
        n_tests++;
        if (bus.dmem_rdata !== 16'h0001) begin
            n_fail++;
            $display("FAIL rise_k1_in: got %h required 0001", bus.dmem_rdata);
        end
        @(negedge sys_clk);
        n_tests++;
        if (bus.dmem_rdata !== 16'h0101 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_k2_flag: rdata=%h irq=%b required 0101 0", bus.dmem_rdata, irq);
        end
        @(negedge sys_clk);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_k3_irq: got %b required 1", irq);
        end
        bus.dmem_wen = 1'b1;
        bus.dmem_byt = 1'b0;
        bus.dmem_wdata = 16'h0100;
        @(negedge sys_clk);
        bus.dmem_wen = 1'b0;
        n_tests++;
        if (bus.dmem_rdata !== 16'h0001 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_flag: rdata=%h irq=%b required 0001 1", bus.dmem_rdata, irq);
        end
        @(negedge sys_clk);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq: got %b required 0", irq);
        end
    endtask

    task automatic test_falling_w1c();
        logic [15:0] rd;
        bus_write(BASE + 10'd20, 16'h0101, 1'b0);
        gpio_i[16] = 1'b1;
        repeat (4) @(negedge sys_clk);
        bus_read(BASE + 10'd18, rd);
        n_tests++;
        if (rd !== 16'h0001) begin
            n_fail++;
            $display("FAIL fall_no_rise: got %h required 0001", rd);
        end
        gpio_i[16] = 1'b0;
        repeat (4) @(negedge sys_clk);
        n_tests++;
        if (bus.dmem_rdata !== 16'h0100 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_flag: rdata=%h irq=%b required 0100 1", bus.dmem_rdata, irq);
        end
        gpio_i[16] = 1'b1;
        repeat (4) @(negedge sys_clk);
        gpio_i[16] = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        bus.dmem_addr = BASE + 10'd19;
        bus.dmem_wen = 1'b1;
        bus.dmem_byt = 1'b1;
        bus.dmem_wdata = 16'h0100;
        @(negedge sys_clk);
        bus.dmem_wen = 1'b0;
        n_tests++;
        if (bus.dmem_rdata !== 16'h0100) begin
            n_fail++;
            $display("FAIL event_beats_w1c: got %h required 0100", bus.dmem_rdata);
        end
        bus_write(BASE + 10'd19, 16'h0100, 1'b1);
        @(negedge sys_clk);
        n_tests++;
        if (bus.dmem_rdata !== 16'h0000 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_clear: rdata=%h irq=%b required 0000 0", bus.dmem_rdata, irq);
        end
    endtask

    task automatic test_dir_and_window();
        logic [15:0] rd;
        bus_write(BASE + 10'd24, 16'h0100, 1'b0);
        bus_write(BASE + 10'd28, 16'h0001, 1'b0);
        gpio_i[24] = 1'b1;
        repeat (4) @(negedge sys_clk);
        bus_read(BASE + 10'd26, rd);
        n_tests++;
        if (rd !== 16'h0001) begin
            n_fail++;
            $display("FAIL dir_out_rise: got %h required 0001", rd);
        end
        gpio_i[24] = 1'b0;
        repeat (4) @(negedge sys_clk);
        n_tests++;
        if (bus.dmem_rdata !== 16'h0000 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_out_noflag: rdata=%h irq=%b required 0000 0", bus.dmem_rdata, irq);
        end
        bus_write(BASE + 10'd6, 16'hFFFF, 1'b0);
        bus_write(10'h0A0, 16'hFFFF, 1'b0);
        bus_read(BASE + 10'd4, rd);
        n_tests++;
        if (rd !== 16'h0000 || gpio_o !== 32'h0000_005A || gpio_oe !== 32'h0100_003C) begin
            n_fail++;
            $display("FAIL ignored_writes: rd=%h o=%h oe=%h required 0000 0000005a 0100003c", rd, gpio_o, gpio_oe);
        end
        bus_read(10'h0A0, rd);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL read_above_window: got %h required 0000", rd);
        end
        bus_read(BASE + 10'd6, rd);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL read_reserved: got %h required 0000", rd);
        end
        bus_read(BASE - 10'd2, rd);
        n_tests++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL read_below_window: got %h required 0000", rd);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge sys_clk);
        bus.dmem_addr = BASE + 10'd8;
        bus.dmem_wen = 1'b1;
        bus.dmem_byt = 1'b1;
        bus.dmem_wdata = 16'h0011;
        @(negedge sys_clk);
        bus.dmem_addr = BASE + 10'd16;
        bus.dmem_wdata = 16'h0022;
        @(negedge sys_clk);
        bus.dmem_wen = 1'b0;
        n_tests++;
        if (gpio_o !== 32'h0022_115A) begin
            n_fail++;
            $display("FAIL b2b_write: got %h required 0022115a", gpio_o);
        end
        bus.dmem_addr = BASE + 10'd8;
        @(negedge sys_clk);
        n_tests++;
        if (bus.dmem_rdata !== 16'h0011) begin
            n_fail++;
            $display("FAIL b2b_read1: got %h required 0011", bus.dmem_rdata);
        end
        bus.dmem_addr = BASE + 10'd16;
        @(negedge sys_clk);
        n_tests++;
        if (bus.dmem_rdata !== 16'h0022) begin
            n_fail++;
            $display("FAIL b2b_read2: got %h required 0022", bus.dmem_rdata);
        end
    endtask

    task automatic test_reset_mid();
        gpio_i[8] = 1'b0;
        repeat (4) @(negedge sys_clk);
        gpio_i[8] = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL premid_irq: got %b required 1", irq);
        end
        bus.dmem_addr = BASE + 10'd10;
        gpio_i = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gpio_o, gpio_oe, irq, bus.dmem_rdata} !== 81'd0) begin
            n_fail++;
            $display("FAIL mid_reset: o=%h oe=%h irq=%b rdata=%h required all 0", gpio_o, gpio_oe, irq, bus.dmem_rdata);
        end
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge sys_clk);
            n_tests++;
            if (bus.dmem_rdata[15:8] !== 8'h00) begin
                n_fail++;
                $display("FAIL rearm_noflag cycle%0d: flag=%h required 00", i, bus.dmem_rdata[15:8]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_rising_irq();
        test_falling_w1c();
        test_dir_and_window();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
